// File: rtl/regwrite_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port: up to four producers,
// one combinational grant per cycle, a registered write beat, and optional bounded burst lock.
module regwrite_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_req,
    input  logic [3:0]        i_lock,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    input  logic [ADDR_W-1:0] i_addr3,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    input  logic              i_stall,
    output logic [3:0]        o_grant,
    output logic [1:0]        o_sel,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]        r_ptr;
    logic [CW-1:0]     r_burst_cnt;
    logic [1:0]        r_sel;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [7:0]        w_rot8;
    logic [3:0]        w_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_win;
    logic              w_any;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Winner search: rotate requests so the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        w_rot8 = {i_req, i_req} >> r_ptr;
        w_rot  = w_rot8[3:0];
        w_off  = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
        w_win  = r_ptr + w_off;
        w_any  = |i_req;
        w_xfer = w_any & ~i_stall & ~i_rst;
        if (w_xfer) begin
            o_grant = 4'b0001 << w_win;
        end else begin
            o_grant = 4'b0000;
        end
    end

    // Address/data select for the winning requester.
    always_comb begin
        w_addr = i_addr0;
        w_data = i_data0;
        case (w_win)
            2'd0: begin w_addr = i_addr0; w_data = i_data0; end
            2'd1: begin w_addr = i_addr1; w_data = i_data1; end
            2'd2: begin w_addr = i_addr2; w_data = i_data2; end
            2'd3: begin w_addr = i_addr3; w_data = i_data3; end
            default: begin w_addr = i_addr0; w_data = i_data0; end
        endcase
    end

    // Pointer / burst counter; a stalled burst keeps its count so it resumes afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= 2'd0;
            r_burst_cnt <= '0;
        end else if (w_xfer) begin
            if (i_lock[w_win] && (r_burst_cnt < CNT_LAST)) begin
                r_ptr       <= w_win;
                r_burst_cnt <= r_burst_cnt + CNT_ONE;
            end else begin
                r_ptr       <= w_win + 2'd1;
                r_burst_cnt <= '0;
            end
        end else if (!w_any && !i_stall) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= r_burst_cnt;
        end
    end

    // Registered write beat; register 0 consumes the grant but is never written.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel     <= 2'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_xfer) begin
            r_sel     <= w_win;
            r_wr_en   <= (w_addr != '0);
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign o_sel     = r_sel;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule
